// File: rtl/regfile_scoreboard.sv
// Parametrised multi-port register file with a per-register busy scoreboard.
// Reads are combinational; writeback data and busy-clear can be forwarded in the same cycle.
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_ena,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN/8-1:0]   wr_be,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_ena,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                any_busy
);
    localparam int unsigned NB = XLEN / 8;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] iss_hit;
    logic [NREG-1:0] busy_eff;
    logic [XLEN-1:0] be_mask;
    logic [AW-1:0]   rd_idx [NRD];

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < NB; b++) begin
            be_mask[8*b +: 8] = {8{wr_be[b]}};
        end
    end

    // Per-register write/issue decode; register 0 never matches when hardwired.
    always_comb begin
        wr_hit  = '0;
        iss_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            wr_hit[r]  = wr_ena  && (wr_addr  == AW'(r)) && !is_zero(AW'(r));
            iss_hit[r] = iss_ena && (iss_addr == AW'(r)) && !is_zero(AW'(r));
        end
    end

    // Flush beats issue, issue beats the writeback clear.
    always_comb begin
        busy_d   = busy_q;
        busy_eff = busy_q;
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = wr_hit[r] ? ((regs_q[r] & ~be_mask) | (wr_data & be_mask)) : regs_q[r];
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_hit[r]) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
            if ((BYPASS != 0) && wr_hit[r]) begin
                busy_eff[r] = iss_hit[r];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_idx[p] = rd_addr[p*AW +: AW];
        end
    end

    // Outputs are forced low while reset is held so forwarding cannot leak through.
    always_comb begin
        rd_data  = '0;
        rd_busy  = '0;
        any_busy = rst_n && (|busy_eff);
        for (int p = 0; p < NRD; p++) begin
            if (rst_n && !is_zero(rd_idx[p])) begin
                if ((BYPASS != 0) && wr_hit[rd_idx[p]]) begin
                    rd_data[p*XLEN +: XLEN] = (regs_q[rd_idx[p]] & ~be_mask) | (wr_data & be_mask);
                    rd_busy[p]              = iss_hit[rd_idx[p]];
                end else begin
                    rd_data[p*XLEN +: XLEN] = regs_q[rd_idx[p]];
                    rd_busy[p]              = busy_q[rd_idx[p]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed checks on three 32-bit configurations sharing
// one stimulus, then a randomised run of a 64-bit, 16-entry, 4-port instance.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        iss_ena;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [9:0]  rd_addr;
    logic [63:0] a_data, b_data, c_data;
    logic [1:0]  a_busy, b_busy, c_busy;
    logic        a_any, b_any, c_any;

    logic         d_wr_ena;
    logic [3:0]   d_wr_addr;
    logic [7:0]   d_wr_be;
    logic [63:0]  d_wr_data;
    logic         d_iss_ena;
    logic [3:0]   d_iss_addr;
    logic         d_flush;
    logic [15:0]  d_rd_addr;
    logic [255:0] d_data;
    logic [3:0]   d_busy;
    logic         d_any;

    // Default configuration.
    regfile_scoreboard u_a (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .iss_ena(iss_ena), .iss_addr(iss_addr), .flush(flush),
        .rd_addr(rd_addr), .rd_data(a_data), .rd_busy(a_busy), .any_busy(a_any)
    );

    // No forwarding.
    regfile_scoreboard #(.BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .iss_ena(iss_ena), .iss_addr(iss_addr), .flush(flush),
        .rd_addr(rd_addr), .rd_data(b_data), .rd_busy(b_busy), .any_busy(b_any)
    );

    // Register 0 is an ordinary register.
    regfile_scoreboard #(.ZERO_REG(0)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .iss_ena(iss_ena), .iss_addr(iss_addr), .flush(flush),
        .rd_addr(rd_addr), .rd_data(c_data), .rd_busy(c_busy), .any_busy(c_any)
    );

    regfile_scoreboard #(.XLEN(64), .NREG(16), .NRD(4)) u_d (
        .clk(clk), .rst_n(rst_n), .wr_ena(d_wr_ena), .wr_addr(d_wr_addr), .wr_be(d_wr_be),
        .wr_data(d_wr_data), .iss_ena(d_iss_ena), .iss_addr(d_iss_addr), .flush(d_flush),
        .rd_addr(d_rd_addr), .rd_data(d_data), .rd_busy(d_busy), .any_busy(d_any)
    );

    // Output selectors: group base + offset for the 32-bit instances, flat for the sweep one.
    localparam int A = 0, B = 5, C = 10;
    localparam int DAT0 = 0, DAT1 = 1, BSY0 = 2, BSY1 = 3, ANY = 4;
    localparam int SD_DATA = 20, SD_BUSY = 24, SD_ANY = 28;

    typedef struct {
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "init";

    logic [63:0] mreg [16];
    logic [15:0] mbusy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        logic [63:0] dv;
        logic [1:0]  bv;
        logic        av;
        if (sel >= SD_ANY) return 64'(d_any);
        if (sel >= SD_BUSY) return 64'(d_busy[sel-SD_BUSY]);
        if (sel >= SD_DATA) return d_data[(sel-SD_DATA)*64 +: 64];
        case (sel / 5)
            0:       begin dv = a_data; bv = a_busy; av = a_any; end
            1:       begin dv = b_data; bv = b_busy; av = b_any; end
            default: begin dv = c_data; bv = c_busy; av = c_any; end
        endcase
        case (sel % 5)
            DAT0:    return 64'(dv[31:0]);
            DAT1:    return 64'(dv[63:32]);
            BSY0:    return 64'(bv[0]);
            BSY1:    return 64'(bv[1]);
            default: return 64'(av);
        endcase
    endfunction

    task automatic want(input int sel, input logic [63:0] v);
        exp_t e;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("%s/sel%0d", phase, e.sel), observe(e.sel), e.exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_ena   = 1'b0;
        wr_addr  = 5'd0;
        wr_be    = 4'h0;
        wr_data  = 32'h0;
        iss_ena  = 1'b0;
        iss_addr = 5'd0;
        flush    = 1'b0;
    endtask

    task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
        rd_addr = {p1, p0};
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_be   = be;
        wr_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_ena  = 1'b1;
        iss_addr = a;
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be);
        logic [63:0] m;
        m = old;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) m[8*b +: 8] = d[8*b +: 8];
        end
        return m;
    endfunction

    task automatic run_sweep();
        logic        wv, iv, eb, any_exp;
        logic [3:0]  a;
        for (int r = 0; r < 16; r++) mreg[r] = '0;
        mbusy = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            next();
            d_wr_ena   = 1'($urandom_range(0, 1));
            d_wr_addr  = 4'($urandom_range(0, 15));
            d_wr_be    = 8'($urandom);
            d_wr_data  = {$urandom, $urandom};
            d_iss_ena  = ($urandom_range(0, 2) == 0);
            d_iss_addr = ($urandom_range(0, 7) == 0) ? d_wr_addr : 4'($urandom_range(0, 15));
            d_flush    = ($urandom_range(0, 31) == 0);
            for (int p = 0; p < 4; p++) begin
                d_rd_addr[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? d_wr_addr
                                                                   : 4'($urandom_range(0, 15));
            end
            wv = d_wr_ena && (d_wr_addr != 4'd0);
            iv = d_iss_ena && (d_iss_addr != 4'd0);
            for (int p = 0; p < 4; p++) begin
                a = d_rd_addr[p*4 +: 4];
                if (a == 4'd0) begin
                    want(SD_DATA + p, 64'h0);
                    want(SD_BUSY + p, 64'h0);
                end else if (wv && (a == d_wr_addr)) begin
                    want(SD_DATA + p, merge(mreg[a], d_wr_data, d_wr_be));
                    want(SD_BUSY + p, 64'(iv && (d_iss_addr == a)));
                end else begin
                    want(SD_DATA + p, mreg[a]);
                    want(SD_BUSY + p, 64'(mbusy[a]));
                end
            end
            any_exp = 1'b0;
            for (int r = 1; r < 16; r++) begin
                if (wv && (d_wr_addr == 4'(r))) eb = iv && (d_iss_addr == 4'(r));
                else eb = mbusy[r];
                any_exp = any_exp | eb;
            end
            want(SD_ANY, 64'(any_exp));
            drain();
            if (wv) mreg[d_wr_addr] = merge(mreg[d_wr_addr], d_wr_data, d_wr_be);
            for (int r = 1; r < 16; r++) begin
                if (d_flush) mbusy[r] = 1'b0;
                else if (iv && (d_iss_addr == 4'(r))) mbusy[r] = 1'b1;
                else if (wv && (d_wr_addr == 4'(r))) mbusy[r] = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        idle();
        rd(5'd3, 5'd5);
        d_wr_ena   = 1'b0;
        d_wr_addr  = 4'd0;
        d_wr_be    = 8'h0;
        d_wr_data  = 64'h0;
        d_iss_ena  = 1'b0;
        d_iss_addr = 4'd0;
        d_flush    = 1'b0;
        d_rd_addr  = 16'h4321;
        #2;
        phase = "reset0";
        want(A + DAT0, 0); want(A + DAT1, 0); want(A + BSY0, 0); want(A + ANY, 0);
        for (int p = 0; p < 4; p++) begin
            want(SD_DATA + p, 0);
            want(SD_BUSY + p, 0);
        end
        want(SD_ANY, 0);
        drain();
        next(); next();
        rst_n = 1'b1;

        phase = "wr3";
        rd(5'd3, 5'd3); wr(5'd3, 4'hF, 32'h12345678);
        want(A + DAT0, 32'h12345678); want(A + DAT1, 32'h12345678); want(B + DAT0, 0);
        drain();
        next(); idle();
        want(A + DAT0, 32'h12345678); want(A + DAT1, 32'h12345678);
        want(B + DAT0, 32'h12345678);
        drain();

        next(); idle();
        phase = "be";
        rd(5'd7, 5'd7); wr(5'd7, 4'hF, 32'hAABBCCDD);
        next(); idle();
        wr(5'd7, 4'b0101, 32'h11223344);
        want(A + DAT0, 32'hAA22CC44); want(B + DAT0, 32'hAABBCCDD);
        drain();
        next(); idle();
        want(A + DAT0, 32'hAA22CC44); want(B + DAT0, 32'hAA22CC44);
        drain();

        next(); idle();
        phase = "zero";
        rd(5'd0, 5'd0); wr(5'd0, 4'hF, 32'hFFFFFFFF); iss(5'd0);
        want(A + DAT0, 0); want(A + BSY0, 0); want(A + ANY, 0);
        want(C + DAT0, 32'hFFFFFFFF); want(C + BSY0, 1);
        drain();
        next(); idle();
        want(A + DAT0, 0); want(A + DAT1, 0); want(A + BSY1, 0); want(A + ANY, 0);
        want(B + DAT0, 0);
        want(C + DAT0, 32'hFFFFFFFF); want(C + BSY0, 1); want(C + ANY, 1);
        drain();
        next(); idle();
        wr(5'd0, 4'h0, 32'h0);
        want(C + BSY0, 0); want(C + ANY, 0); want(C + DAT0, 32'hFFFFFFFF);
        drain();
        next(); idle();
        want(C + BSY0, 0); want(C + DAT0, 32'hFFFFFFFF);
        drain();

        next(); idle();
        phase = "busy";
        rd(5'd9, 5'd9); iss(5'd9);
        want(A + BSY0, 0); want(A + ANY, 0);
        drain();
        next(); idle();
        want(A + BSY0, 1); want(A + BSY1, 1); want(A + ANY, 1); want(B + BSY0, 1);
        drain();
        next(); idle();
        wr(5'd9, 4'hF, 32'h5);
        want(A + BSY0, 0); want(A + ANY, 0); want(A + DAT0, 32'h5);
        want(B + BSY0, 1); want(B + DAT0, 0); want(B + ANY, 1);
        drain();
        next(); idle();
        want(A + BSY0, 0); want(A + ANY, 0); want(B + BSY0, 0); want(B + DAT0, 32'h5);
        drain();
        next(); idle();
        iss(5'd9); wr(5'd9, 4'hF, 32'h6);
        want(A + BSY0, 1); want(A + DAT0, 32'h6);
        drain();
        next(); idle();
        want(A + BSY0, 1); want(A + ANY, 1); want(B + BSY0, 1); want(A + DAT0, 32'h6);
        drain();

        next(); idle();
        phase = "flush";
        rd(5'd4, 5'd9); flush = 1'b1; iss(5'd4); wr(5'd4, 4'hF, 32'hCAFEF00D);
        want(A + DAT0, 32'hCAFEF00D); want(A + BSY1, 1); want(B + DAT0, 0);
        drain();
        next(); idle();
        want(A + BSY0, 0); want(A + BSY1, 0); want(A + ANY, 0); want(A + DAT0, 32'hCAFEF00D);
        want(B + DAT0, 32'hCAFEF00D); want(B + BSY0, 0); want(B + ANY, 0); want(C + ANY, 0);
        drain();

        next(); idle();
        phase = "rst";
        rd(5'd5, 5'd5); iss(5'd5); wr(5'd5, 4'hF, 32'hDEADBEEF);
        next(); idle();
        want(A + DAT0, 32'hDEADBEEF); want(A + BSY0, 1); want(B + DAT0, 32'hDEADBEEF);
        drain();
        wr(5'd5, 4'hF, 32'h1); iss(5'd5); rst_n = 1'b0;
        want(A + DAT0, 0); want(A + DAT1, 0); want(A + BSY0, 0); want(A + ANY, 0);
        want(B + DAT0, 0); want(C + DAT0, 0); want(C + ANY, 0);
        drain();
        next(); idle();
        rst_n = 1'b1;
        want(A + DAT0, 0); want(A + BSY0, 0); want(A + ANY, 0);
        want(B + DAT0, 0); want(B + BSY0, 0);
        drain();

        phase = "sweep";
        run_sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
